// File: rtl/token_mult_pkg.sv
// Shared types and sizing helpers for the serial token multiplier.
package token_mult_pkg;

    // Width of a credit counter able to hold 0..cmax inclusive.
    function automatic int credit_width(input int cmax);
        return (cmax < 1) ? 1 : $clog2(cmax + 1);
    endfunction

    // Per-lane decision taken on an enabled cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // no token, no credit: output low
        ACCEPT = 2'd1,   // token fits: emit and add f_eff-1 credit
        DROP   = 2'd2,   // token would exceed credit limit: flag and drain
        DRAIN  = 2'd3    // no token, credit pending: emit and decrement
    } lane_action_e;

endpackage

// File: rtl/token_mult_lane.sv
// One lane of the token multiplier: credit counter, registered output token,
// busy flag and sticky overflow flag.
module token_mult_lane
    import token_mult_pkg::*;
#(
    parameter int FACTOR_W   = 3,
    parameter int CREDIT_MAX = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                a,
    input  logic [FACTOR_W-1:0] factor,
    output logic                b,
    output logic                busy,
    output logic                overflow
);

    localparam int CW = credit_width(CREDIT_MAX);
    // Wide enough that credit + factor - 1 can never wrap.
    localparam int SW = CW + FACTOR_W + 1;

    logic [CW-1:0]       credit;
    logic [CW-1:0]       credit_next;
    logic [FACTOR_W-1:0] f_eff;
    logic [SW-1:0]       sum;
    logic                fits;
    logic                has_credit;
    lane_action_e        action;
    logic                b_next;
    logic                ovf_set;

    // Effective factor and the widened post-accept credit value.
    always_comb begin
        f_eff      = (factor == '0) ? FACTOR_W'(1) : factor;
        sum        = SW'(credit) + SW'(f_eff) - SW'(1);
        fits       = (sum <= SW'(CREDIT_MAX));
        has_credit = (credit != '0);
    end

    // Decode the lane action; a dropped token behaves like a=0 for output/credit.
    always_comb begin
        action = IDLE;
        if (a && fits)
            action = ACCEPT;
        else if (a)
            action = DROP;
        else if (has_credit)
            action = DRAIN;
    end

    // Next-state values for credit, output token and overflow.
    always_comb begin
        credit_next = credit;
        b_next      = 1'b0;
        ovf_set     = 1'b0;
        case (action)
            ACCEPT: begin
                credit_next = sum[CW-1:0];
                b_next      = 1'b1;
            end
            DROP: begin
                ovf_set = 1'b1;
                if (has_credit) begin
                    credit_next = credit - CW'(1);
                    b_next      = 1'b1;
                end
            end
            DRAIN: begin
                credit_next = credit - CW'(1);
                b_next      = 1'b1;
            end
            default: begin
                credit_next = credit;
                b_next      = 1'b0;
            end
        endcase
    end

    // Lane state: reset wins, en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit   <= '0;
            b        <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else if (en) begin
            credit   <= credit_next;
            b        <= b_next;
            busy     <= (credit_next != '0);
            overflow <= overflow | ovf_set;
        end
    end

endmodule

// File: rtl/token_multiplier.sv
// Multi-lane serial token multiplier: each accepted '1' on a lane expands into
// f_eff contiguous output '1's. Lanes are independent; this level only slices.
module token_multiplier
    import token_mult_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FACTOR_W   = 3,
    parameter int CREDIT_MAX = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CHANNELS-1:0]          a,
    input  logic [CHANNELS*FACTOR_W-1:0] factor,
    output logic [CHANNELS-1:0]          b,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          overflow
);

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_lane
        token_mult_lane #(
            .FACTOR_W   (FACTOR_W),
            .CREDIT_MAX (CREDIT_MAX)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .a        (a[i]),
            .factor   (factor[i*FACTOR_W +: FACTOR_W]),
            .b        (b[i]),
            .busy     (busy[i]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier: one task per scenario, inline checks.
module tb_token_multiplier;

    localparam int CHANNELS   = 4;
    localparam int FACTOR_W   = 3;
    localparam int CREDIT_MAX = 200;

    logic                         clk;
    logic                         rst;
    logic                         en;
    logic [CHANNELS-1:0]          a;
    logic [CHANNELS*FACTOR_W-1:0] factor;
    logic [CHANNELS-1:0]          b;
    logic [CHANNELS-1:0]          busy;
    logic [CHANNELS-1:0]          overflow;

    int checks;
    int errors;

    token_multiplier #(
        .CHANNELS   (CHANNELS),
        .FACTOR_W   (FACTOR_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .factor   (factor),
        .b        (b),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_factor(input int lane, input int val);
        factor[lane*FACTOR_W +: FACTOR_W] = FACTOR_W'(val);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (b !== 4'b0000 || busy !== 4'b0000 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: b=%b busy=%b ovf=%b, want all 0", b, busy, overflow);
        end
        tick();
        checks++;
        if (b !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: b=%b busy=%b, want 0000/0000", b, busy);
        end
    endtask

    // Lane0 factor=2 against the reference pattern.
    task automatic test_pattern();
        logic [25:0] pat;
        logic [25:0] exp;
        pat = 26'b10010011000110100001100100;
        exp = 26'b11011011110111111001111110;
        set_factor(0, 2);
        for (int i = 25; i >= 0; i--) begin
            a[0] = pat[i];
            tick();
            checks++;
            if (b[0] !== exp[i]) begin
                errors++;
                $display("FAIL pattern_b[%0d]: got %b want %b", 25 - i, b[0], exp[i]);
            end
        end
        a[0] = 1'b0;
        checks++;
        if (overflow !== 4'b0000 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL pattern_end: ovf=%b busy0=%b, want 0000/0", overflow, busy[0]);
        end
    endtask

    // Lane1 factor=3, single token: three '1's, busy for the first two.
    task automatic test_single_token();
        logic [3:0] exp_b;
        logic [3:0] exp_busy;
        exp_b    = 4'b1110;
        exp_busy = 4'b1100;
        set_factor(1, 3);
        a[1] = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick();
            a[1] = 1'b0;
            checks++;
            if (b[1] !== exp_b[i] || busy[1] !== exp_busy[i]) begin
                errors++;
                $display("FAIL single_token[%0d]: b=%b busy=%b want b=%b busy=%b",
                         3 - i, b[1], busy[1], exp_b[i], exp_busy[i]);
            end
        end
    endtask

    // Lane2 factor=2: 200 tokens fill credit exactly; the 201st overflows.
    task automatic test_credit_boundary();
        int ones;
        int bad;
        int cyc;
        ones = 0;
        bad  = 0;
        set_factor(2, 2);
        a[2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b[2] !== 1'b1 || overflow[2] !== 1'b0) bad++;
            if (b[2] === 1'b1) ones++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL boundary_fill: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (overflow[2] !== 1'b0 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL boundary_200: ovf=%b busy=%b want 0/1", overflow[2], busy[2]);
        end
        tick();   // 201st token
        a[2] = 1'b0;
        if (b[2] === 1'b1) ones++;
        checks++;
        if (overflow !== 4'b0100 || b[2] !== 1'b1) begin
            errors++;
            $display("FAIL boundary_201: ovf=%b b2=%b want 0100/1", overflow, b[2]);
        end
        cyc = 0;
        while (b[2] === 1'b1 && cyc < 300) begin
            tick();
            cyc++;
            if (b[2] === 1'b1) ones++;
        end
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL boundary_drain_timeout: b2 still %b after %0d cycles", b[2], cyc);
        end
        checks++;
        if (ones != 400) begin
            errors++;
            $display("FAIL boundary_total: got %0d ones want 400", ones);
        end
    endtask

    // After overflow the lane still accepts; overflow clears only on reset.
    task automatic test_overflow_recovery();
        logic [2:0] exp_b;
        exp_b = 3'b110;
        a = '0;
        for (int i = 0; i < 5; i++) tick();
        a[2] = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            a[2] = 1'b0;
            checks++;
            if (b[2] !== exp_b[i] || overflow[2] !== 1'b1) begin
                errors++;
                $display("FAIL recover[%0d]: b2=%b ovf2=%b want %b/1", 2 - i, b[2], overflow[2], exp_b[i]);
            end
        end
        do_reset();
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL recover_rst: ovf=%b want 0000", overflow);
        end
    endtask

    // factor 0 and 1 both pass tokens through one-for-one.
    task automatic test_factor_zero_one();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int f = 0; f < 2; f++) begin
            set_factor(3, f);
            for (int i = 3; i >= 0; i--) begin
                a[3] = pat[i];
                tick();
                checks++;
                if (b[3] !== pat[i] || busy[3] !== 1'b0) begin
                    errors++;
                    $display("FAIL factor%0d[%0d]: b3=%b busy3=%b want %b/0", f, 3 - i, b[3], busy[3], pat[i]);
                end
            end
            a[3] = 1'b0;
            tick();
        end
    endtask

    // Freeze mid-drain, resume briefly, then reset discards pending credit.
    task automatic test_freeze_reset();
        set_factor(0, 6);   // credit 5
        set_factor(1, 4);   // credit 3
        a = 4'b0011;
        tick();
        a = '0;
        checks++;
        if (b[1:0] !== 2'b11 || busy[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL freeze_load: b=%b busy=%b want xx11/xx11", b, busy);
        end
        en = 1'b0;
        a  = 4'b0100;       // ignored while frozen
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b !== 4'b0011 || busy !== 4'b0011) begin
                errors++;
                $display("FAIL freeze[%0d]: b=%b busy=%b want 0011/0011", i, b, busy);
            end
        end
        a  = '0;
        en = 1'b1;
        // Credits 5/3 -> 4/2 -> 3/1: both lanes still busy.
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (b !== 4'b0011 || busy !== 4'b0011) begin
                errors++;
                $display("FAIL resume[%0d]: b=%b busy=%b want 0011/0011", i, b, busy);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (b !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_rst: b=%b busy=%b want 0000/0000", b, busy);
        end
        tick();
        checks++;
        if (b !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL post_rst_idle: b=%b busy=%b want 0000/0000", b, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b1;
        a      = '0;
        factor = '0;
        test_reset();
        test_pattern();
        test_single_token();
        test_credit_boundary();
        test_overflow_recovery();
        test_factor_zero_one();
        test_freeze_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
